// File: rtl/and_pulse_sampler.sv
// Capture stage for the clocked-AND gate model: decodes toggle-encoded pulses into result words.
// Optional orphan-pulse checking is enabled by defining AND_SAMPLER_ORPHAN_CHECK_EN.
module and_pulse_sampler #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate_clk,
  input  logic             gate_out,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             err_extra,
  output logic             err_orphan,
  output logic             err_overrun,
  input  logic             err_clear
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
  localparam logic [7:0] WinLast = 8'(WINDOW - 1);

  localparam logic StIdle = 1'b0;
  localparam logic StOpen = 1'b1;

  logic [2:0]       gclk_sync_q, gout_sync_q;
  logic             clk_pulse, out_pulse;
  logic             state_q, state_d;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic             hit_q, hit_d;
  logic             commit, commit_bit, extra_set, orphan_set;
  logic [WIDTH-1:0] shift_q, shift_d, word_next;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             complete, load;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_extra_q, err_overrun_q;

  // Two synchronizer flops plus one history flop; an edge on either line becomes a 1-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gclk_sync_q <= '0;
      gout_sync_q <= '0;
    end else begin
      gclk_sync_q <= {gclk_sync_q[1:0], gate_clk};
      gout_sync_q <= {gout_sync_q[1:0], gate_out};
    end
  end

  assign clk_pulse = gclk_sync_q[1] ^ gclk_sync_q[2];
  assign out_pulse = gout_sync_q[1] ^ gout_sync_q[2];

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    hit_d      = hit_q;
    commit     = 1'b0;
    commit_bit = hit_q | out_pulse;
    extra_set  = 1'b0;
    orphan_set = 1'b0;
    case (state_q)
      StIdle: begin
        orphan_set = out_pulse;
        if (clk_pulse) begin
          state_d   = StOpen;
          win_cnt_d = '0;
          hit_d     = 1'b0;
        end
      end
      StOpen: begin
        extra_set = out_pulse & hit_q;
        if (clk_pulse) begin
          // Same-cycle output pulse belongs to the closing window, then a fresh one opens.
          commit    = 1'b1;
          win_cnt_d = '0;
          hit_d     = 1'b0;
        end else if (win_cnt_q == WinLast) begin
          commit    = 1'b1;
          state_d   = StIdle;
          win_cnt_d = '0;
          hit_d     = 1'b0;
        end else begin
          win_cnt_d = win_cnt_q + 8'd1;
          hit_d     = hit_q | out_pulse;
        end
      end
    endcase
  end

  always_comb begin
    word_next            = shift_q;
    word_next[bit_cnt_q] = commit_bit;
    shift_d              = commit ? word_next : shift_q;
    complete             = commit && (bit_cnt_q == BitLast);
    bit_cnt_d            = bit_cnt_q;
    if (commit) bit_cnt_d = complete ? '0 : bit_cnt_q + CntW'(1);
  end

  always_comb begin
    load    = complete && (!valid_q || word_ready);
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = word_next;
      valid_d = 1'b1;
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      win_cnt_q     <= '0;
      hit_q         <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      err_extra_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      hit_q         <= hit_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      err_extra_q   <= (err_extra_q & ~err_clear) | extra_set;
      err_overrun_q <= (err_overrun_q & ~err_clear) | (complete & ~load);
    end
  end

`ifdef AND_SAMPLER_ORPHAN_CHECK_EN
  logic err_orphan_q;
  always_ff @(posedge clk) begin
    if (!rst_n) err_orphan_q <= 1'b0;
    else        err_orphan_q <= (err_orphan_q & ~err_clear) | orphan_set;
  end
  assign err_orphan = err_orphan_q;
`else
  logic unused_orphan;
  assign unused_orphan = orphan_set;
  assign err_orphan    = 1'b0;
`endif

  assign word_data   = data_q;
  assign word_valid  = valid_q;
  assign err_extra   = err_extra_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_and_pulse_sampler.sv
// Bench for and_pulse_sampler: directed scenarios plus random pulse trains vs. a window model.
module tb_and_pulse_sampler;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned WINDOW = 16;
`ifdef AND_SAMPLER_ORPHAN_CHECK_EN
  localparam logic OrphanEn = 1'b1;
`else
  localparam logic OrphanEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             gate_clk = 1'b0;
  logic             gate_out = 1'b0;
  logic             word_ready = 1'b0;
  logic             err_clear = 1'b0;
  logic [WIDTH-1:0] word_data;
  logic             word_valid, err_extra, err_orphan, err_overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] got_q[$];

  and_pulse_sampler #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gate_clk   (gate_clk),
    .gate_out   (gate_out),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .err_extra  (err_extra),
    .err_orphan (err_orphan),
    .err_overrun(err_overrun),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && word_valid && word_ready) got_q.push_back(word_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One gate period: clock edge, optional output edge dly cycles later, gap cycles total.
  task automatic period(input bit hit, input int dly, input int gap);
    gate_clk = ~gate_clk;
    if (hit) begin
      wait_cyc(dly);
      gate_out = ~gate_out;
      wait_cyc(gap - dly);
    end else begin
      wait_cyc(gap);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    gate_clk = 1'b0;
    gate_out = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int k = 0; k < WIDTH; k++) period(w[k], 4, 20);
  endtask

  int cq[$];
  int oq[$];
  bit bits[$];

  initial begin
    int last_c, last_o, c, close_t, cnt, latest, nw;
    bit found, exp_extra, exp_orph;
    logic [WIDTH-1:0] ew;
    logic [7:0] w8d;

    // Reset with toggling inputs.
    wait_cyc(1);
    for (int i = 0; i < 3; i++) begin
      gate_clk = ~gate_clk;
      gate_out = ~gate_out;
      wait_cyc(1);
    end
    check_eq("rst_data", 32'(word_data), 32'h0);
    check_eq("rst_valid", 32'(word_valid), 32'h0);
    check_eq("rst_extra", 32'(err_extra), 32'h0);
    check_eq("rst_orphan", 32'(err_orphan), 32'h0);
    check_eq("rst_overrun", 32'(err_overrun), 32'h0);
    gate_clk = 1'b0;
    gate_out = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(10);
    check_eq("rst_no_word", 32'(word_valid), 32'h0);

    // Hits on periods 0,2,3,7 give 8'h8D.
    word_ready = 1'b0;
    w8d = 8'h8D;
    for (int k = 0; k < 8; k++) period(w8d[k], 6, 40);
    check_eq("w8d_valid", 32'(word_valid), 32'h1);
    check_eq("w8d_data", 32'(word_data), 32'h8D);
    check_eq("w8d_extra", 32'(err_extra), 32'h0);
    check_eq("w8d_orphan", 32'(err_orphan), 32'h0);
    word_ready = 1'b1;
    wait_cyc(1);
    check_eq("w8d_drop", 32'(word_valid), 32'h0);
    word_ready = 1'b0;

    // Extra pulse, clear, orphan pulse.
    do_reset();
    gate_clk = ~gate_clk;
    wait_cyc(3);
    gate_out = ~gate_out;
    wait_cyc(5);
    gate_out = ~gate_out;
    wait_cyc(32);
    check_eq("extra_set", 32'(err_extra), 32'h1);
    err_clear = 1'b1;
    wait_cyc(1);
    err_clear = 1'b0;
    check_eq("extra_clr", 32'(err_extra), 32'h0);
    gate_clk = ~gate_clk;
    wait_cyc(30);
    gate_out = ~gate_out;
    wait_cyc(10);
    check_eq("orphan", 32'(err_orphan), 32'(OrphanEn));
    for (int k = 0; k < 6; k++) period(1'b0, 4, 20);
    wait_cyc(3);
    check_eq("eo_valid", 32'(word_valid), 32'h1);
    check_eq("eo_data", 32'(word_data), 32'h01);

    // Overrun: second word dropped while first is held.
    do_reset();
    send_word(8'hA5);
    wait_cyc(3);
    check_eq("ovr_a_valid", 32'(word_valid), 32'h1);
    check_eq("ovr_a_data", 32'(word_data), 32'hA5);
    check_eq("ovr_none", 32'(err_overrun), 32'h0);
    send_word(8'h3C);
    wait_cyc(3);
    check_eq("ovr_set", 32'(err_overrun), 32'h1);
    check_eq("ovr_held", 32'(word_data), 32'hA5);
    word_ready = 1'b1;
    wait_cyc(1);
    check_eq("ovr_drain", 32'(word_valid), 32'h0);

    // Reset mid-word discards partial bits.
    do_reset();
    for (int k = 0; k < 3; k++) period(1'b0, 4, 20);
    do_reset();
    word_ready = 1'b0;
    send_word(8'hFF);
    wait_cyc(3);
    check_eq("mid_valid", 32'(word_valid), 32'h1);
    check_eq("mid_data", 32'(word_data), 32'hFF);

    // Random pulse trains against the window model.
    do_reset();
    word_ready = 1'b1;
    mon_en = 1'b1;
    last_c = -100;
    last_o = -100;
    for (int i = 0; i < 3000; i++) begin
      if (cyc - last_c >= 3 && $urandom_range(0, 11) == 0) begin
        gate_clk = ~gate_clk;
        last_c = cyc;
        cq.push_back(cyc + 3);
      end
      if (cyc - last_o >= 3 && $urandom_range(0, 9) == 0) begin
        gate_out = ~gate_out;
        last_o = cyc;
        oq.push_back(cyc + 3);
      end
      @(negedge clk);
    end
    wait_cyc(WINDOW + 20);
    mon_en = 1'b0;

    exp_extra = 1'b0;
    exp_orph = 1'b0;
    for (int i = 0; i < cq.size(); i++) begin
      c = cq[i];
      close_t = c + WINDOW;
      if (i + 1 < cq.size() && cq[i+1] < close_t) close_t = cq[i+1];
      cnt = 0;
      foreach (oq[j]) if (oq[j] > c && oq[j] <= close_t) cnt++;
      bits.push_back(cnt > 0);
      if (cnt > 1) exp_extra = 1'b1;
    end
    foreach (oq[j]) begin
      found = 1'b0;
      latest = 0;
      foreach (cq[i]) if (cq[i] < oq[j]) begin
        found = 1'b1;
        latest = cq[i];
      end
      if (!found || oq[j] > latest + WINDOW) exp_orph = 1'b1;
    end
    nw = bits.size() / WIDTH;
    check_eq("rand_nwords", 32'(got_q.size()), 32'(nw));
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < WIDTH; b++) ew[b] = bits[w*WIDTH + b];
      if (w < got_q.size()) check_eq($sformatf("rand_word%0d", w), 32'(got_q[w]), 32'(ew));
    end
    check_eq("rand_extra", 32'(err_extra), 32'(exp_extra));
    check_eq("rand_orphan", 32'(err_orphan), 32'(exp_orph & OrphanEn));
    check_eq("rand_overrun", 32'(err_overrun), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
